// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared cache/memory geometry and handshake state encoding.
package cache_mem_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W = 5;
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} mem_state_t;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: word-wide synchronous write port, whole-block read port for cache refill.
module mem_word_array
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = cache_mem_pkg::ADDR_W,
    parameter int DATA_W = cache_mem_pkg::DATA_W,
    parameter int WORDS_PER_BLOCK = cache_mem_pkg::WORDS_PER_BLOCK,
    parameter int OFF_W = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic [DATA_W-1:0]                 wdata,
    input  logic [ADDR_W-OFF_W-1:0]           rblk,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0] rblock
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    for (genvar i = 0; i < WORDS_PER_BLOCK; i++) begin : g_rd
        assign rblock[DATA_W*i +: DATA_W] = mem[{rblk, OFF_W'(i)}];
    end
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency backing store answering cache block reads and word writes.
// Define MEM_PROTOCOL_CHECK_EN to build the sticky handshake checker behind protocol_err.
module main_memory_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = cache_mem_pkg::ADDR_W,
    parameter int DATA_W = cache_mem_pkg::DATA_W,
    parameter int WORDS_PER_BLOCK = cache_mem_pkg::WORDS_PER_BLOCK,
    parameter int LATENCY = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_read_access,
    input  logic                              mem_write_access,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [DATA_W-1:0]                 write_data,
    output logic                              ready,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0] read_block,
    output logic                              busy,
    output logic                              protocol_err
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t state, state_d;
    logic op_write, access, load_block;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-OFF_W-1:0] rd_blk;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W*WORDS_PER_BLOCK-1:0] array_block;

    assign access = mem_read_access | mem_write_access;
    // In IDLE the block is read straight from the request so LATENCY==1 can capture at acceptance.
    assign rd_blk = (state == IDLE) ? address[ADDR_W-1:OFF_W] : addr_q[ADDR_W-1:OFF_W];

    always_comb begin
        state_d = (state == IDLE) ? (access ? ((LATENCY == 1) ? RESPOND : BUSY) : IDLE) :
                  (state == BUSY) ? ((cnt == CNT_W'(1)) ? RESPOND : BUSY) : IDLE;
        load_block = (state_d == RESPOND) && ((state == IDLE) ? mem_read_access : !op_write);
    end

    mem_word_array #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLOCK(WORDS_PER_BLOCK), .OFF_W(OFF_W)
    ) u_array (
        .clk(clk), .we(state == RESPOND && op_write), .waddr(addr_q), .wdata(wdata_q),
        .rblk(rd_blk), .rblock(array_block)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
            read_block <= '0;
            cnt        <= '0;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_d;
            ready <= state_d == RESPOND;
            busy  <= state_d != IDLE;
            if (state == IDLE && access) begin
                op_write <= !mem_read_access;
                addr_q   <= address;
                wdata_q  <= write_data;
                cnt      <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
            end
            if (load_block) read_block <= array_block;
        end
    end

`ifdef MEM_PROTOCOL_CHECK_EN
    logic after_resp, viol;

    always_comb
        viol = (state == IDLE && mem_read_access && mem_write_access) ||
               (state == BUSY && (op_write ? !mem_write_access : !mem_read_access)) ||
               (after_resp && state == IDLE && address == addr_q &&
                ((mem_read_access && !op_write) || (mem_write_access && op_write)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            after_resp   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            after_resp <= state == RESPOND;
            if (viol) begin
                protocol_err <= 1'b1;
                $error("main_memory_responder: handshake violation in state %s", state.name());
            end
        end
    end
`else
    assign protocol_err = 1'b0;
`endif
endmodule
